// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared constants and types for the GPR write-back arbiter: data width,
// register addressing and the source index encoding used by the round-robin.
package gpr_writeback_arbiter_pkg;

   localparam int GPU_DDATA_WIDTH = 32;
   localparam int REG_AW          = 5;
   localparam int NREG            = 32;
   localparam int NSRC            = 3;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_LSU = 2'd1,
      SRC_MDU = 2'd2
   } src_e;

   // Successor in the rotating priority order ALU -> LSU -> MDU -> ALU.
   function automatic src_e next_src(input src_e s);
      case (s)
         SRC_ALU: next_src = SRC_LSU;
         SRC_LSU: next_src = SRC_MDU;
         default: next_src = SRC_ALU;
      endcase
   endfunction

endpackage

// File: rtl/gpr_wb_rr_arb3.sv
// Three-requester round-robin arbiter: one-hot grant from the requests and a
// rotating priority pointer that moves past the most recent winner.
module gpr_wb_rr_arb3
   import gpr_writeback_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  i_req,
   output logic [2:0]  o_gnt,
   output logic        o_any,
   output src_e        o_src
);

   src_e r_ptr;
   logic w_any;
   src_e w_src;

   // NOTE: every variable written here gets a default first, otherwise the
   // paths that do not assign it would infer a latch.
   always_comb begin
      src_e cand;
      w_any = 1'b0;
      w_src = r_ptr;
      cand  = r_ptr;
      for (int i = 0; i < NSRC; i++) begin
         if (!w_any && i_req[cand]) begin
            w_any = 1'b1;
            w_src = cand;
         end
         cand = next_src(cand);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= SRC_ALU;
      end else if (w_any) begin
         r_ptr <= next_src(w_src);
      end
   end

   assign o_gnt = w_any ? (3'b001 << w_src) : 3'b000;
   assign o_any = w_any;
   assign o_src = w_src;

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Single write-port producer for the integer GPR file: arbitrates ALU/LSU/MDU
// results, registers the write and tracks pending destinations.
module gpr_writeback_arbiter
   import gpr_writeback_arbiter_pkg::*;
#(
   parameter int DW = GPU_DDATA_WIDTH
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [DW-1:0]     alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [DW-1:0]     lsu_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [REG_AW-1:0] mdu_rd,
   input  logic [DW-1:0]     mdu_data,
   input  logic              sb_set_valid,
   input  logic [REG_AW-1:0] sb_set_addr,
   output logic [NREG-1:0]   sb_busy,
   output logic              rd0_wen,
   output logic [REG_AW-1:0] rd0_addr,
   output logic [DW-1:0]     rd0_data
);

   logic [2:0]        w_req;
   logic [2:0]        w_gnt;
   logic              w_any;
   src_e              w_src;
   logic [REG_AW-1:0] w_rd;
   logic [DW-1:0]     w_data;
   logic              w_commit;
   logic [NREG-1:0]   w_busy_nxt;

   logic              r_wen;
   logic [REG_AW-1:0] r_addr;
   logic [DW-1:0]     r_data;
   logic [NREG-1:0]   r_busy;

   // Requests are masked in reset so no ready can escape while rst_n is low.
   assign w_req = {mdu_valid, lsu_valid, alu_valid} & {3{rst_n}};

   gpr_wb_rr_arb3 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req),
      .o_gnt (w_gnt),
      .o_any (w_any),
      .o_src (w_src)
   );

   assign alu_ready = w_gnt[SRC_ALU];
   assign lsu_ready = w_gnt[SRC_LSU];
   assign mdu_ready = w_gnt[SRC_MDU];

   always_comb begin
      w_rd   = alu_rd;
      w_data = alu_data;
      case (w_src)
         SRC_LSU: begin
            w_rd   = lsu_rd;
            w_data = lsu_data;
         end
         SRC_MDU: begin
            w_rd   = mdu_rd;
            w_data = mdu_data;
         end
         default: ;
      endcase
   end

   // A grant to x0 is consumed but never reaches the register file.
   assign w_commit = w_any && (w_rd != '0);

   // Set is applied after clear so a new producer wins over a retiring one.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_commit) begin
         w_busy_nxt[w_rd] = 1'b0;
      end
      if (sb_set_valid && (sb_set_addr != '0)) begin
         w_busy_nxt[sb_set_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_wen <= w_commit;
         if (w_commit) begin
            r_addr <= w_rd;
            r_data <= w_data;
         end
      end
   end

   // NOTE: the scoreboard must be reset; stale busy bits after reset would
   // stall issue forever on destinations nobody is going to write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign rd0_wen  = r_wen;
   assign rd0_addr = r_addr;
   assign rd0_data = r_data;
   assign sb_busy  = r_busy;

endmodule

// File: doc/gpr_writeback_arbiter.md
Name: gpr_writeback_arbiter

Overview:
- Write-side producer for the integer GPR file's single write port (rd0_addr / rd0_data / write enable).
- Collects results from three execution sources (ALU, LSU load-return, MDU mul/div) over valid/ready handshakes.
- Grants one source per cycle round-robin and drives a registered write into the GPR.
- Keeps a 32-entry busy scoreboard that issue logic uses to stall on pending destinations.

Parameters:
- DW, `GPU_DDATA_WIDTH (from global_defines.vh): result/write data width.
- NREG, 32: architectural register count; fixed, addresses 5 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  DW  ALU result
- lsu_valid / lsu_ready / lsu_rd / lsu_data  in/out/in/in  1/1/5/DW  load-return channel, same semantics
- mdu_valid / mdu_ready / mdu_rd / mdu_data  in/out/in/in  1/1/5/DW  mul/div channel, same semantics
- sb_set_valid  in  1  issue marks a destination as pending
- sb_set_addr  in  5  register being marked
- sb_busy  out  32  per-register pending bits; bit 0 always 0
- rd0_wen  out  1  GPR write enable, one-cycle pulse
- rd0_addr  out  5  GPR write address
- rd0_data  out  DW  GPR write data

Behaviour:
- Reset (async assert, sync-safe release):
  - rd0_wen=0, rd0_addr=0, rd0_data=0, sb_busy=0.
  - Round-robin pointer=0 (ALU highest). All *_ready=0 while rst_n=0.
- Handshake:
  - A transfer occurs when valid & ready are high at a rising edge.
  - A source holds valid, rd and data stable until accepted.
  - ready is combinational from the valids and the pointer; ready may depend on valid. Valid must never depend on ready.
- Arbitration:
  - At most one ready per cycle.
  - Priority order starts at pointer p (0=ALU, 1=LSU, 2=MDU) and rotates: p, p+1, p+2 mod 3. First valid source in that order is granted.
  - After a grant to source k, p ← (k+1) mod 3. With no grant, p holds.
  - Worst-case wait for a continuously valid source: 2 cycles.
- Latency:
  - Grant at edge N → rd0_wen/rd0_addr/rd0_data valid in the cycle after edge N (registered). The GPR captures at edge N+1.
  - No grant → rd0_wen=0 next cycle; rd0_addr/rd0_data hold their last values.
- x0 handling:
  - A transfer with rd=0 is accepted (ready asserted normally) and consumes the grant.
  - rd0_wen stays 0 for it; the scoreboard is unchanged.
- Scoreboard:
  - On a committed write to r (rd≠0), busy[r] clears at the same edge the write registers (edge N).
  - sb_set_valid with addr≠0 sets busy[addr] at the next edge; addr=0 is ignored.
  - Simultaneous set and clear of the same r in one edge: set wins (a new producer is in flight).
- Ordering:
  - No reordering between sources is checked. Issue logic is responsible for WAW via sb_busy.
  - A write for a register whose busy bit is already 0 is still performed.
- Reset mid-operation: any pending grant is discarded, no write is issued, and all busy bits are cleared.
- Width: data passes unmodified, with no sign or zero extension. Extension is the LSU's responsibility.

Decomposition:
- Shared package/header (global_defines.vh): GPU_DDATA_WIDTH, source index constants SRC_ALU=0, SRC_LSU=1, SRC_MDU=2, register address width 5.
- One sub-module: gpr_wb_rr_arb3 — 3-requester round-robin grant plus pointer register.
- Scoreboard and write register stay in the top module.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle → alu_ready=1. Next cycle rd0_wen=1, rd0_addr=5, rd0_data=0x1234; the following cycle rd0_wen=0.
2. All three valid continuously (rd=1/2/3) from reset → grants ALU, LSU, MDU, ALU… Writes to r1, r2, r3, r1 on consecutive cycles; no source waits more than 2 cycles.
3. sb_set_valid addr=7, then lsu write rd=7 → sb_busy[7]=1 after set and 0 at the write edge. With set and write to 7 on the same edge, busy[7] stays 1.
4. mdu_valid rd=0 data=0xFFFF → mdu_ready=1, rd0_wen=0 next cycle, sb_busy unchanged, pointer advances to ALU.
5. Hold lsu_valid while alu and mdu also valid, then assert rst_n=0 mid-stream → all outputs 0 and sb_busy=0 immediately. After release the first grant goes to ALU.
6. sb_set_valid addr=0 → sb_busy[0] remains 0.
